// File: rtl/pio_pattern_master.sv
// pio_pattern_master: Avalon-MM write master that serialises a latched bit
// pattern onto a single-bit output PIO. Each bit is one write to the PIO data
// register (address 0), spaced by a programmable gap. A stop request ends with
// a write to the PIO clear register (address 5) so the output is forced low.
module pio_pattern_master #(
  parameter int PATTERN_W = 16,
  parameter int LEN_W     = 5,
  parameter int PERIOD_W  = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic [LEN_W-1:0]     length,
  input  logic [PERIOD_W-1:0]  period,
  input  logic                 repeat_en,
  input  logic                 waitrequest,
  output logic [2:0]           address,
  output logic                 chipselect,
  output logic                 write_n,
  output logic                 writedata,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  localparam logic [2:0]       ADDR_DATA = 3'd0;
  localparam logic [2:0]       ADDR_CLR  = 3'd5;
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(PATTERN_W);

  // Lengths beyond the pattern register are clamped to its full width.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

  // A zero gap would stall the counter, so it behaves as a one-cycle gap.
  function automatic logic [PERIOD_W-1:0] norm_period(input logic [PERIOD_W-1:0] p);
    return (p == '0) ? PERIOD_W'(1) : p;
  endfunction

  // Control state
  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                stop_pend_q, stop_pend_d;
  logic                done_d;
  logic                load_cfg;

  // Configuration latched on an accepted start (no reset needed: only read
  // after a start has loaded it)
  logic [PATTERN_W-1:0] pat_q;
  logic [LEN_W-1:0]     len_q;
  logic [PERIOD_W-1:0]  per_q;
  logic                 rep_q;

  // Next-cycle bus values, registered so every output is a flop
  logic [PATTERN_W-1:0] pat_n;
  logic                 last_bit;
  logic                 bit_d;
  logic                 cs_d;
  logic [2:0]           addr_d;
  logic                 wd_d;

  // Next-state logic for the sequencer FSM
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    load_cfg    = 1'b0;
    last_bit    = (LEN_W'(idx_q) == (len_q - 1'b1));
    case (state_q)
      S_IDLE: begin
        if (stop) begin
          state_d = S_CLEAR;
        end else if (start) begin
          if (length != '0) begin
            load_cfg = 1'b1;
            idx_d    = '0;
            state_d  = S_WRITE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (stop) stop_pend_d = 1'b1;
        if (!waitrequest) begin
          if (stop || stop_pend_q) begin
            state_d     = S_CLEAR;
            stop_pend_d = 1'b0;
          end else if (last_bit && !rep_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = last_bit ? '0 : idx_q + 1'b1;
            cnt_d   = per_q;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (stop) begin
          state_d = S_CLEAR;
        end else if (cnt_q <= PERIOD_W'(1)) begin
          cnt_d   = '0;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (!waitrequest) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase

    pat_n  = load_cfg ? pattern : pat_q;
    bit_d  = pat_n[idx_d];
    cs_d   = (state_d == S_WRITE) || (state_d == S_CLEAR);
    addr_d = (state_d == S_CLEAR) ? ADDR_CLR : ADDR_DATA;
    wd_d   = (state_d == S_WRITE) ? bit_d : (state_d == S_CLEAR);
  end

  // FSM, index, gap counter and registered bus outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      address     <= ADDR_DATA;
      chipselect  <= 1'b0;
      write_n     <= 1'b1;
      writedata   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      address     <= addr_d;
      chipselect  <= cs_d;
      write_n     <= ~cs_d;
      writedata   <= wd_d;
      busy        <= (state_d != S_IDLE);
      done        <= done_d;
    end
  end

  // Configuration capture on accepted start
  always_ff @(posedge clk) begin
    if (load_cfg) begin
      pat_q <= pattern;
      len_q <= clamp_len(length);
      per_q <= norm_period(period);
      rep_q <= repeat_en;
    end
  end

endmodule

// File: tb/tb_pio_pattern_master.sv
// Directed bench for pio_pattern_master. Outputs are packed per cycle into
// {busy, done, chipselect, write_n, address, writedata} and compared against
// hand-derived cycle tables.
module tb_pio_pattern_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop;
  logic [15:0] pattern;
  logic [4:0]  length;
  logic [23:0] period;
  logic        repeat_en;
  logic        waitrequest;
  logic [2:0]  address;
  logic        chipselect, write_n, writedata, busy, done;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [7:0] IDLE_V  = 8'h10;
  localparam logic [7:0] GAP_V   = 8'h90;
  localparam logic [7:0] DONE_V  = 8'h50;
  localparam logic [7:0] CLEAR_V = 8'hAB;

  pio_pattern_master #(.PATTERN_W(16), .LEN_W(5), .PERIOD_W(24)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pattern(pattern),
    .length(length), .period(period), .repeat_en(repeat_en),
    .waitrequest(waitrequest), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] snap();
    return {busy, done, chipselect, write_n, address, writedata};
  endfunction

  function automatic logic [7:0] wr_v(input logic d);
    return 8'hA0 | {7'd0, d};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [15:0] p, input logic [4:0] l,
                     input logic [23:0] per, input logic r);
    pattern = p; length = l; period = per; repeat_en = r;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [7:0]  e;
  logic [15:0] pv;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; waitrequest = 1'b0;
    cfg(16'h0000, 5'd0, 24'd0, 1'b0);
    #1;
    check("reset_async", snap(), IDLE_V);
    tick(); tick();
    check("reset_held", snap(), IDLE_V);
    reset = 1'b0;
    tick();
    check("after_release", snap(), IDLE_V);

    // Basic sequence: writes in cycles 1,5,9,13 with data 1,1,0,1; done in 14
    cfg(16'h000B, 5'd4, 24'd3, 1'b0);
    pulse_start();
    for (int c = 1; c <= 14; c++) begin
      case (c)
        1: e = wr_v(1'b1);
        5: e = wr_v(1'b1);
        9: e = wr_v(1'b0);
        13: e = wr_v(1'b1);
        14: e = DONE_V;
        default: e = GAP_V;
      endcase
      check($sformatf("basic_c%0d", c), snap(), e);
      tick();
    end
    check("basic_idle", snap(), IDLE_V);

    // Wait states in cycles 5-6: second write held 5-7, third in 11
    pulse_start();
    for (int c = 1; c <= 16; c++) begin
      waitrequest = (c == 5) || (c == 6);
      case (c)
        1, 5, 6, 7, 15: e = wr_v(1'b1);
        11: e = wr_v(1'b0);
        16: e = DONE_V;
        default: e = GAP_V;
      endcase
      check($sformatf("wait_c%0d", c), snap(), e);
      tick();
    end
    waitrequest = 1'b0;
    check("wait_idle", snap(), IDLE_V);

    // Repeat, then stop in a GAP cycle
    cfg(16'h0002, 5'd2, 24'd1, 1'b1);
    pulse_start();
    for (int c = 1; c <= 8; c++) begin
      e = (c % 2 == 1) ? wr_v(((c - 1) / 2) % 2 == 1) : GAP_V;
      check($sformatf("rep_c%0d", c), snap(), e);
      stop = (c == 8);
      tick();
    end
    stop = 1'b0;
    check("rep_clear", snap(), CLEAR_V);
    tick();
    check("rep_done", snap(), DONE_V);
    tick();
    check("rep_idle", snap(), IDLE_V);

    // Stop during a stalled write: write completes, then CLEAR with no GAP
    pulse_start();
    stop = 1'b1; waitrequest = 1'b1;
    check("wstop_c1", snap(), wr_v(1'b0));
    tick();
    stop = 1'b0;
    check("wstop_c2", snap(), wr_v(1'b0));
    tick();
    waitrequest = 1'b0;
    check("wstop_c3", snap(), wr_v(1'b0));
    tick();
    check("wstop_clear", snap(), CLEAR_V);
    tick();
    check("wstop_done", snap(), DONE_V);
    tick();
    check("wstop_idle", snap(), IDLE_V);

    // Zero length: done only, no bus activity, busy stays low
    cfg(16'hFFFF, 5'd0, 24'd2, 1'b0);
    pulse_start();
    check("zero_done", snap(), DONE_V);
    tick();
    check("zero_idle", snap(), IDLE_V);
    tick();
    check("zero_idle2", snap(), IDLE_V);

    // Length clamp (20 -> 16) with period 0 treated as 1
    pv = 16'h8001;
    cfg(pv, 5'd20, 24'd0, 1'b0);
    pulse_start();
    for (int c = 1; c <= 32; c++) begin
      if (c == 32) e = DONE_V;
      else if (c % 2 == 1) e = wr_v(pv[(c - 1) / 2]);
      else e = GAP_V;
      check($sformatf("clamp_c%0d", c), snap(), e);
      tick();
    end
    check("clamp_idle", snap(), IDLE_V);

    // Reset while a write is held by waitrequest
    cfg(16'h000B, 5'd4, 24'd3, 1'b0);
    waitrequest = 1'b1;
    pulse_start();
    check("rst_w1", snap(), wr_v(1'b1));
    tick();
    check("rst_w2", snap(), wr_v(1'b1));
    #2 reset = 1'b1;
    #1;
    check("rst_mid", snap(), IDLE_V);
    #2 reset = 1'b0;
    waitrequest = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("rst_after_c%0d", c), snap(), IDLE_V);
    end

    // Start while busy is ignored (new config on inputs must not matter)
    cfg(16'h000B, 5'd4, 24'd3, 1'b0);
    pulse_start();
    for (int c = 1; c <= 14; c++) begin
      case (c)
        1: e = wr_v(1'b1);
        5: e = wr_v(1'b1);
        9: e = wr_v(1'b0);
        13: e = wr_v(1'b1);
        14: e = DONE_V;
        default: e = GAP_V;
      endcase
      check($sformatf("busy_start_c%0d", c), snap(), e);
      if (c == 3 || c == 5) begin
        cfg(16'h0000, 5'd1, 24'd0, 1'b1);
        start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    check("busy_start_idle", snap(), IDLE_V);

    // Start and stop together in IDLE: only the clear write
    cfg(16'h000B, 5'd4, 24'd3, 1'b0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("both_clear", snap(), CLEAR_V);
    tick();
    check("both_done", snap(), DONE_V);
    tick();
    check("both_idle", snap(), IDLE_V);
    tick();
    check("both_idle2", snap(), IDLE_V);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
